// File: rtl/tw_addr_seq.sv
// tw_addr_seq: radix-2 FFT butterfly address pair and twiddle index sequencer.
// Define TW_ADDR_SEQ_DIF_EN for decimation-in-frequency stage order (default DIT).
module tw_addr_seq #(
   parameter int N = 8192
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         abort,
   output logic                         busy,
   output logic                         done,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(N)-1:0]         idx_a,
   output logic [$clog2(N)-1:0]         idx_b,
   output logic [$clog2(N/2)-1:0]       k_out,
   output logic [$clog2($clog2(N))-1:0] stage_out,
   output logic                         last_in_stage
);
   localparam int L = $clog2(N);
   localparam int SW = $clog2(L);
   localparam logic [SW-1:0] LAST_ST = SW'(L - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [L-2:0] b, nb, mask, j, nk;
   logic [SW-1:0] nst;
   logic [L-1:0] bw, half, na, nbb;
   logic xfer, fin;
   int s;
   assign xfer = out_valid & out_ready;
   assign fin = (stage_out == LAST_ST) & (&b);
   // next triple: first one when leaving IDLE, else the successor of the current one
   always_comb begin
      nb = (state == IDLE) ? '0 : b + 1'b1;
      nst = (state == IDLE) ? '0 : ((&b) ? stage_out + 1'b1 : stage_out);
`ifdef TW_ADDR_SEQ_DIF_EN
      s = L - 1 - int'(nst);
`else
      s = int'(nst);
`endif
      half = {{(L-1){1'b0}}, 1'b1} << s;
      mask = half[L-2:0] - 1'b1;
      j = nb & mask;
      bw = {1'b0, nb};
      na = ((bw >> s) << (s + 1)) | {1'b0, j};
      nbb = na + half;
      nk = j << (L - 1 - s);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy <= 1'b0;
         done <= 1'b0;
         out_valid <= 1'b0;
         b <= '0;
         stage_out <= '0;
         idx_a <= '0;
         idx_b <= '0;
         k_out <= '0;
         last_in_stage <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state <= RUN;
                  busy <= 1'b1;
                  out_valid <= 1'b1;
                  b <= nb;
                  stage_out <= nst;
                  idx_a <= na;
                  idx_b <= nbb;
                  k_out <= nk;
                  last_in_stage <= &nb;
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
                  busy <= 1'b0;
                  out_valid <= 1'b0;
               end else if (xfer && fin) begin
                  state <= DONE;
                  busy <= 1'b0;
                  out_valid <= 1'b0;
                  done <= 1'b1;
               end else if (xfer) begin
                  b <= nb;
                  stage_out <= nst;
                  idx_a <= na;
                  idx_b <= nbb;
                  k_out <= nk;
                  last_in_stage <= &nb;
               end
            end
            default: begin
               state <= IDLE;
               done <= 1'b0;
            end
         endcase
      end
   end
endmodule
